// File: rtl/bit_count_requester.sv
// Initiator for the single-word bit-count handshake: buffers upstream words,
// issues them one at a time to a bit-count responder and returns each count.
module bit_count_requester #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        cnt_valid,
    output logic [31:0] cnt_data,
    input  logic        cnt_ready,
    input  logic [31:0] cnt_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [5:0]  res_data,
    output logic [31:0] res_word,
    output logic [15:0] done_count,
    output logic        err_timeout
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_timer;

    logic        r_cnt_valid;
    logic [31:0] r_cnt_data;
    logic        r_res_valid;
    logic [5:0]  r_res_data;
    logic [31:0] r_res_word;
    logic [15:0] r_done_count;
    logic        r_err_timeout;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_capture;
    logic        w_release;
    logic        w_timeout;
    logic        w_expire;
    logic        w_unused_result;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_expire = (r_timer == 8'(TIMEOUT - 1));

    // Only the low six result bits carry a count; the rest are ignored.
    assign w_unused_result = ^cnt_result[31:6];

    assign cnt_valid   = r_cnt_valid;
    assign cnt_data    = r_cnt_data;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_word    = r_res_word;
    assign done_count  = r_done_count;
    assign err_timeout = r_err_timeout;

    // FIFO storage, written on accepted upstream words
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && cnt_ready) begin
                    w_next_state = S_ISSUE;
                    w_pop        = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (w_expire) begin
                    w_next_state = S_IDLE;
                    w_timeout    = 1'b1;
                end else if (!cnt_ready) begin
                    w_next_state = S_WAIT_HI;
                end else begin
                    w_next_state = S_WAIT_LO;
                end
            end
            S_WAIT_HI: begin
                // A result arriving on the last allowed cycle still counts.
                if (cnt_ready) begin
                    w_next_state = S_HOLD;
                    w_capture    = 1'b1;
                end else if (w_expire) begin
                    w_next_state = S_IDLE;
                    w_timeout    = 1'b1;
                end else begin
                    w_next_state = S_WAIT_HI;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_next_state = S_IDLE;
                    w_release    = 1'b1;
                end else begin
                    w_next_state = S_HOLD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Response timer: cleared entering WAIT_LO, counts through both wait states
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= 8'd0;
        end else if (r_state == S_ISSUE) begin
            r_timer <= 8'd0;
        end else if ((r_state == S_WAIT_LO) || (r_state == S_WAIT_HI)) begin
            r_timer <= r_timer + 8'd1;
        end else begin
            r_timer <= r_timer;
        end
    end

    // Registered request, result, tally and error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_valid   <= 1'b0;
            r_cnt_data    <= 32'd0;
            r_res_valid   <= 1'b0;
            r_res_data    <= 6'd0;
            r_res_word    <= 32'd0;
            r_done_count  <= 16'd0;
            r_err_timeout <= 1'b0;
        end else begin
            r_cnt_valid <= w_pop;
            if (w_pop) begin
                r_cnt_data <= r_mem[r_rd_ptr];
            end
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_data  <= cnt_result[5:0];
                r_res_word  <= r_cnt_data;
            end else if (w_release) begin
                r_res_valid <= 1'b0;
            end
            if (w_release) begin
                r_done_count <= r_done_count + 16'd1;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_count_requester.sv
// Self-checking bench for bit_count_requester with a behavioural responder
// and a queue-based scoreboard of expected words and counts.
module tb_bit_count_requester;

    localparam int DEPTH = 4;
    localparam int TO    = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic        cnt_valid;
    logic [31:0] cnt_data;
    logic        cnt_ready = 1'b1;
    logic [31:0] cnt_result = 32'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [5:0]  res_data;
    logic [31:0] res_word;
    logic [15:0] done_count;
    logic        err_timeout;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    int          exp_done = 0;
    int          hs_q[$];
    logic [5:0]  got_q[$];
    int          cyc = 0;

    bit          resp_block = 1'b0;
    bit          resp_stuck = 1'b0;
    bit          resp_stall = 1'b0;
    int          resp_phase = 0;
    logic [31:0] resp_word = 32'd0;

    logic [89:0] rst_exp = {1'b1, 1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 16'h0, 1'b0};

    bit_count_requester #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cnt_valid(cnt_valid), .cnt_data(cnt_data),
        .cnt_ready(cnt_ready), .cnt_result(cnt_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_word(res_word),
        .done_count(done_count), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder rule: bit31 set -> ones in [30:0], else zeros in [30:0]
    function automatic logic [5:0] model(input logic [31:0] w);
        int c = 0;
        for (int i = 0; i < 31; i++) c += int'(w[i]);
        return w[31] ? 6'(c) : 6'(31 - c);
    endfunction

    // Responder: Ready falls the cycle after Valid is seen, rises with result one later
    initial begin
        logic        rst_seen;
        logic [31:0] junk;
        forever begin
            @(posedge clk);
            rst_seen = rst;
            #1;
            if (rst_seen) begin
                resp_phase = 0;
                cnt_ready  = 1'b1;
            end else if (resp_phase == 2) begin
                if (!resp_stall) begin
                    junk       = $urandom();
                    cnt_result = {junk[31:6], model(resp_word)};
                    cnt_ready  = 1'b1;
                    resp_phase = 0;
                end
            end else if (resp_phase == 1) begin
                cnt_ready  = 1'b0;
                resp_phase = 2;
            end else if (resp_block) begin
                cnt_ready = 1'b0;
            end else begin
                cnt_ready = 1'b1;
                if (cnt_valid && !resp_stuck) begin
                    resp_word  = cnt_data;
                    resp_phase = 1;
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        int k = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL push_wait: in_ready stayed %b, required 1", in_ready);
        end else begin
            @(posedge clk); #1;
            exp_q.push_back(w);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input bit rnd);
        int          got = 0;
        int          k = 0;
        bit          prev_v = 1'b0;
        logic [31:0] w;
        while (got < n && k < 2000) begin
            @(negedge clk);
            k++;
            if (cnt_valid) begin
                n_checks++;
                if (prev_v) $display("FAIL cnt_valid_pulse: high %0d cycles, required 1", 2);
                else n_pass++;
            end
            prev_v = cnt_valid;
            if (res_valid && res_ready) begin
                w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_checks++;
                if (res_word !== w) $display("FAIL res_word: got %h required %h", res_word, w);
                else n_pass++;
                n_checks++;
                if (res_data !== model(w)) $display("FAIL res_data: got %0d required %0d (word %h)", res_data, model(w), w);
                else n_pass++;
                n_checks++;
                if (done_count !== 16'(exp_done)) $display("FAIL done_count: got %0d required %0d", done_count, exp_done);
                else n_pass++;
                got_q.push_back(res_data);
                hs_q.push_back(cyc);
                exp_done++;
                got++;
            end
            @(posedge clk); #1;
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        n_checks++;
        if (got != n) $display("FAIL drain_count: got %0d results required %0d", got, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        int pulses = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, cnt_valid, cnt_data, res_valid, res_data, res_word, done_count, err_timeout} !== rst_exp)
            $display("FAIL reset_state: got %h required %h",
                     {in_ready, cnt_valid, cnt_data, res_valid, res_data, res_word, done_count, err_timeout}, rst_exp);
        else n_pass++;
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (cnt_valid || res_valid) pulses++;
        end
        n_checks++;
        if (pulses != 0 || in_ready !== 1'b1) $display("FAIL idle_quiet: got %0d pulses in_ready %b required 0/1", pulses, in_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                n_checks++;
                if (cnt_valid !== 1'b1 || cnt_data !== 32'hFFFF_FFFF)
                    $display("FAIL single_issue: got %b/%h required 1/ffffffff", cnt_valid, cnt_data);
                else n_pass++;
            end else if (k == 2) begin
                n_checks++;
                if (cnt_valid !== 1'b0) $display("FAIL single_pulse: got %b required 0", cnt_valid);
                else n_pass++;
            end else if (k == 3) begin
                n_checks++;
                if (res_valid !== 1'b0) $display("FAIL single_early: got %b required 0", res_valid);
                else n_pass++;
            end else if (k == 4) begin
                n_checks++;
                if (res_valid !== 1'b1 || res_data !== 6'd31 || res_word !== 32'hFFFF_FFFF)
                    $display("FAIL single_result: got %b/%0d/%h required 1/31/ffffffff", res_valid, res_data, res_word);
                else n_pass++;
            end else begin
                n_checks++;
                if (res_valid !== 1'b0 || done_count !== 16'd1)
                    $display("FAIL single_done: got %b/%0d required 0/1", res_valid, done_count);
                else n_pass++;
            end
        end
        exp_done = 1;
    endtask

    task automatic test_burst();
        resp_block = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        push_word(32'h0000_0000);
        push_word(32'h8000_0001);
        push_word(32'h0000_FFFF);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL burst_ready3: got %b required 1", in_ready);
        else n_pass++;
        push_word($urandom());
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL burst_full: got %b required 0", in_ready);
        else n_pass++;
        hs_q.delete();
        got_q.delete();
        res_ready  = 1'b1;
        resp_block = 1'b0;
        drain(4, 1'b0);
        n_checks++;
        if (got_q.size() < 3 || got_q[0] !== 6'd31 || got_q[1] !== 6'd1 || got_q[2] !== 6'd15)
            $display("FAIL burst_order: got %p required 31,1,15", got_q);
        else n_pass++;
        for (int i = 0; i + 1 < hs_q.size(); i++) begin
            n_checks++;
            if (hs_q[i+1] - hs_q[i] != 5) $display("FAIL burst_gap: got %0d cycles required 5", hs_q[i+1] - hs_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (done_count !== 16'(exp_done)) $display("FAIL burst_done: got %0d required %0d", done_count, exp_done);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int          k = 0;
        logic [5:0]  d;
        logic [31:0] w;
        res_ready = 1'b0;
        push_word($urandom());
        push_word($urandom() | 32'h8000_0000);
        push_word($urandom() & 32'h7FFF_FFFF);
        while (!res_valid && k < 50) begin @(posedge clk); #1; k++; end
        d = res_data;
        w = res_word;
        n_checks++;
        if (!res_valid || w !== exp_q[0] || d !== model(exp_q[0]))
            $display("FAIL bp_first: got %b/%h/%0d required 1/%h/%0d", res_valid, w, d, exp_q[0], model(exp_q[0]));
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== d || res_word !== w || cnt_valid !== 1'b0)
                $display("FAIL bp_hold: got %b/%0d/%h/%b required 1/%0d/%h/0", res_valid, res_data, res_word, cnt_valid, d, w);
            else n_pass++;
        end
        push_word($urandom());
        push_word($urandom());
        n_checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b1) $display("FAIL bp_backup: got %b/%b required 0/1", in_ready, res_valid);
        else n_pass++;
        res_ready = 1'b1;
        drain(5, 1'b0);
        n_checks++;
        if (done_count !== 16'(exp_done)) $display("FAIL bp_done: got %0d required %0d", done_count, exp_done);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit seen_res = 1'b0;
        res_ready  = 1'b1;
        resp_stuck = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= TO + 2; k++) begin
            @(posedge clk); #1;
            if (res_valid) seen_res = 1'b1;
            if (k == TO + 1) begin
                n_checks++;
                if (err_timeout !== 1'b0) $display("FAIL to_early: got %b required 0", err_timeout);
                else n_pass++;
            end else if (k == TO + 2) begin
                n_checks++;
                if (err_timeout !== 1'b1) $display("FAIL to_set: got %b required 1", err_timeout);
                else n_pass++;
            end
        end
        n_checks++;
        if (seen_res || done_count !== 16'(exp_done))
            $display("FAIL to_nores: got res %b done %0d required 0/%0d", seen_res, done_count, exp_done);
        else n_pass++;
        resp_stuck = 1'b0;
        push_word(32'h8001_00FF);
        drain(1, 1'b0);
        n_checks++;
        if (err_timeout !== 1'b1) $display("FAIL to_sticky: got %b required 1", err_timeout);
        else n_pass++;
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 15; it++) begin
            n = $urandom_range(1, DEPTH);
            resp_block = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            for (int j = 0; j < n; j++) push_word($urandom());
            resp_block = 1'b0;
            res_ready  = 1'($urandom_range(0, 1));
            drain(n, 1'b1);
            n_checks++;
            if (done_count !== 16'(exp_done)) $display("FAIL rand_done: got %0d required %0d", done_count, exp_done);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int noise = 0;
        res_ready  = 1'b1;
        resp_block = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        push_word($urandom());
        push_word($urandom());
        push_word($urandom());
        resp_stall = 1'b1;
        resp_block = 1'b0;
        while (!cnt_valid && k < 20) begin @(posedge clk); #1; k++; end
        n_checks++;
        if (!cnt_valid) $display("FAIL mid_issue: got %b required 1", cnt_valid);
        else n_pass++;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, cnt_valid, cnt_data, res_valid, res_data, res_word, done_count, err_timeout} !== rst_exp)
            $display("FAIL mid_reset: got %h required %h",
                     {in_ready, cnt_valid, cnt_data, res_valid, res_data, res_word, done_count, err_timeout}, rst_exp);
        else n_pass++;
        rst = 1'b0;
        exp_q.delete();
        exp_done   = 0;
        resp_stall = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (cnt_valid || res_valid) noise++;
        end
        n_checks++;
        if (noise != 0) $display("FAIL mid_flush: got %0d active cycles required 0", noise);
        else n_pass++;
        push_word(32'h7FFF_0000);
        drain(1, 1'b0);
        n_checks++;
        if (done_count !== 16'd1) $display("FAIL mid_done: got %0d required 1", done_count);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
